// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60) and the RGB444 pixel type.
package vga_timing_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  // Total period of one axis: visible area plus porches and sync.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with blank and sync decode.
// Used for columns (always enabled) and for lines (enabled on column wrap).
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int WID    = 10,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  output logic [WID-1:0] cnt,
  output logic [WID-1:0] next_cnt,
  output logic           wrap,
  output logic           blank,
  output logic           sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  // The counter must be able to represent TOTAL-1.
  if (TOTAL - 1 >= (1 << WID)) begin : g_wid_check
    $error("vga_axis_counter: WID too small for TOTAL-1");
  end

  localparam logic [WID-1:0] LAST       = WID'(TOTAL - 1);
  localparam logic [WID-1:0] ACT_END    = WID'(ACTIVE);
  localparam logic [WID-1:0] SYNC_START = WID'(ACTIVE + FP);
  localparam logic [WID-1:0] SYNC_LAST  = WID'(ACTIVE + FP + SYNC - 1);

  logic [WID-1:0] cnt_q, cnt_d;

  // Next position, wrap detect and region decode from the current count.
  always_comb begin
    wrap     = (cnt_q == LAST);
    next_cnt = wrap ? '0 : cnt_q + WID'(1);
    cnt_d    = en ? next_cnt : cnt_q;
    blank    = (cnt_q >= ACT_END);
    sync     = (cnt_q >= SYNC_START) && (cnt_q <= SYNC_LAST);
  end

  // Position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator and registered pad stage.
// Optional build macro SHADYPONG_FRAME_CNT_EN adds an 8-bit frame counter port.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_CNT_WID = 10,
  parameter int V_CNT_WID = 10,
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit SYNC_NEG  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 pixIf_NEXT_FRAME,
  output logic                 pixIf_H_BLANKING,
  output logic [H_CNT_WID-1:0] pixIf_H_CNT,
  output logic [V_CNT_WID-1:0] pixIf_next_V_CNT,
  input  logic [3:0]           pixIf_r,
  input  logic [3:0]           pixIf_g,
  input  logic [3:0]           pixIf_b,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic [3:0]           vga_r,
  output logic [3:0]           vga_g,
  output logic [3:0]           vga_b
`ifdef SHADYPONG_FRAME_CNT_EN
  ,
  output logic [7:0]           frame_cnt
`endif
);

  logic                 h_wrap, h_blank, h_sync;
  logic                 v_wrap, v_blank, v_sync;
  logic [H_CNT_WID-1:0] h_cnt, h_next_unused;
  logic [V_CNT_WID-1:0] v_cnt_unused, v_next_cnt;
  logic                 next_frame;

  vga_axis_counter #(
    .WID(H_CNT_WID), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .en(1'b1),
    .cnt(h_cnt), .next_cnt(h_next_unused), .wrap(h_wrap),
    .blank(h_blank), .sync(h_sync)
  );

  vga_axis_counter #(
    .WID(V_CNT_WID), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .en(h_wrap),
    .cnt(v_cnt_unused), .next_cnt(v_next_cnt), .wrap(v_wrap),
    .blank(v_blank), .sync(v_sync)
  );

  assign next_frame       = h_wrap && v_wrap;
  assign pixIf_NEXT_FRAME = next_frame;
  assign pixIf_H_BLANKING = h_blank;
  assign pixIf_H_CNT      = h_cnt;
  assign pixIf_next_V_CNT = v_next_cnt;

  rgb444_t pix_in, rgb_d, rgb_q;
  logic    hsync_d, hsync_q, vsync_d, vsync_q;
  logic    blank;

  // Pad stage input: blank colour outside the visible area, apply sync polarity.
  always_comb begin
    pix_in  = {pixIf_r, pixIf_g, pixIf_b};
    blank   = h_blank || v_blank;
    rgb_d   = blank ? rgb444_t'('0) : pix_in;
    hsync_d = h_sync ^ SYNC_NEG;
    vsync_d = v_sync ^ SYNC_NEG;
  end

  // Pad stage register: colour and both syncs share one stage so they stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q   <= '0;
      hsync_q <= SYNC_NEG;
      vsync_q <= SYNC_NEG;
    end else begin
      rgb_q   <= rgb_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign vga_r     = rgb_q.r;
  assign vga_g     = rgb_q.g;
  assign vga_b     = rgb_q.b;
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;

`ifdef SHADYPONG_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Frame count advances on the edge that ends the last pixel of a frame.
  always_comb begin
    frame_cnt_d = next_frame ? frame_cnt_q + 8'd1 : frame_cnt_q;
  end

  // Frame counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a scaled-down raster (16x12) for frame-level
// behaviour, an active-high-sync copy, and a default 640x480 copy for line timing.
module tb_vga_timing_gen;

  // Scaled raster used for frame-level tests.
  localparam int SHA = 10, SHF = 2, SHS = 2, SHB = 2;   // H_TOTAL 16
  localparam int SVA = 6,  SVF = 2, SVS = 2, SVB = 2;   // V_TOTAL 12
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int FL  = SHT * SVT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_r = '0, in_g = '0, in_b = '0;

  logic       s_nf, s_hb, s_hs, s_vs;
  logic [3:0] s_h, s_nv, s_r, s_g, s_b;
  logic       p_nf, p_hb, p_hs, p_vs;
  logic [3:0] p_h, p_nv, p_r, p_g, p_b;
  logic       d_nf, d_hb, d_hs, d_vs;
  logic [9:0] d_h, d_nv;
  logic [3:0] d_r, d_g, d_b;
`ifdef SHADYPONG_FRAME_CNT_EN
  logic [7:0] s_fc, p_fc, d_fc;
`endif

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_CNT_WID(4), .V_CNT_WID(4),
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_NEG(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixIf_NEXT_FRAME(s_nf), .pixIf_H_BLANKING(s_hb),
    .pixIf_H_CNT(s_h), .pixIf_next_V_CNT(s_nv), .pixIf_r(in_r), .pixIf_g(in_g),
    .pixIf_b(in_b), .vga_hsync(s_hs), .vga_vsync(s_vs), .vga_r(s_r), .vga_g(s_g),
    .vga_b(s_b)
`ifdef SHADYPONG_FRAME_CNT_EN
    , .frame_cnt(s_fc)
`endif
  );

  vga_timing_gen #(
    .H_CNT_WID(4), .V_CNT_WID(4),
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_NEG(1'b0)
  ) dut_pos (
    .clk(clk), .rst_n(rst_n), .pixIf_NEXT_FRAME(p_nf), .pixIf_H_BLANKING(p_hb),
    .pixIf_H_CNT(p_h), .pixIf_next_V_CNT(p_nv), .pixIf_r(in_r), .pixIf_g(in_g),
    .pixIf_b(in_b), .vga_hsync(p_hs), .vga_vsync(p_vs), .vga_r(p_r), .vga_g(p_g),
    .vga_b(p_b)
`ifdef SHADYPONG_FRAME_CNT_EN
    , .frame_cnt(p_fc)
`endif
  );

  vga_timing_gen dut_def (
    .clk(clk), .rst_n(rst_n), .pixIf_NEXT_FRAME(d_nf), .pixIf_H_BLANKING(d_hb),
    .pixIf_H_CNT(d_h), .pixIf_next_V_CNT(d_nv), .pixIf_r(in_r), .pixIf_g(in_g),
    .pixIf_b(in_b), .vga_hsync(d_hs), .vga_vsync(d_vs), .vga_r(d_r), .vga_g(d_g),
    .vga_b(d_b)
`ifdef SHADYPONG_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  int          k = 0;            // active clock edges since reset release
  logic [11:0] rgb_prev = '0;    // colour presented before the latest edge

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] nv;
    logic        hb;
    logic        nf;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } exp_t;

  // Expected observable state after k edges, from raster arithmetic alone.
  function automatic exp_t model(input int kk, input int ha, input int hf, input int hs,
                                 input int hb, input int va, input int vf, input int vs,
                                 input int vb, input logic [11:0] rgb_in, input bit neg);
    exp_t e;
    int ht, vt, h, v, ph, pv;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h  = kk % ht;
    v  = (kk / ht) % vt;
    e.h  = 16'(h);
    e.nv = 16'((v + 1) % vt);
    e.hb = (h >= ha);
    e.nf = (h == ht - 1) && (v == vt - 1);
    if (kk == 0) begin
      e.rgb = '0;
      e.hs  = neg;
      e.vs  = neg;
    end else begin
      ph = (kk - 1) % ht;
      pv = ((kk - 1) / ht) % vt;
      e.rgb = (ph < ha && pv < va) ? rgb_in : 12'h000;
      e.hs  = (ph >= ha + hf && ph < ha + hf + hs) ^ neg;
      e.vs  = (pv >= va + vf && pv < va + vf + vs) ^ neg;
    end
    return e;
  endfunction

  // Present a colour, take one edge, land on the following falling edge.
  task automatic step(input logic [11:0] rgb);
    {in_r, in_g, in_b} = rgb;
    @(posedge clk);
    k++;
    rgb_prev = rgb;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {in_r, in_g, in_b} = 12'hABC;
    repeat (3) @(negedge clk);
    checks++; if (s_h !== 4'd0) begin errors++; $display("FAIL reset_h_cnt got %0d want 0", s_h); end
    checks++; if (s_nv !== 4'd1) begin errors++; $display("FAIL reset_next_v got %0d want 1", s_nv); end
    checks++; if (s_hb !== 1'b0 || s_nf !== 1'b0) begin errors++; $display("FAIL reset_flags got hb=%b nf=%b want 0 0", s_hb, s_nf); end
    checks++; if ({s_r, s_g, s_b} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", {s_r, s_g, s_b}); end
    checks++; if (s_hs !== 1'b1 || s_vs !== 1'b1) begin errors++; $display("FAIL reset_sync_neg got %b%b want 11", s_hs, s_vs); end
    checks++; if (p_hs !== 1'b0 || p_vs !== 1'b0) begin errors++; $display("FAIL reset_sync_pos got %b%b want 00", p_hs, p_vs); end
    checks++; if (d_h !== 10'd0 || d_nv !== 10'd1) begin errors++; $display("FAIL reset_def_cnt got h=%0d nv=%0d want 0 1", d_h, d_nv); end
    rst_n = 1'b1;
    k = 0;
  endtask

  // Two frames of random colour on the scaled raster, both sync polarities.
  task automatic test_frame();
    exp_t e, ep;
    int pulses = 0;
    do_reset();
    for (int i = 0; i < 2 * FL; i++) begin
      e  = model(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, rgb_prev, 1'b1);
      ep = model(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, rgb_prev, 1'b0);
      if (s_nf === 1'b1) pulses++;
      checks++; if (s_h !== e.h[3:0]) begin errors++; $display("FAIL frame_h_cnt k=%0d got %0d want %0d", k, s_h, e.h); end
      checks++; if (s_nv !== e.nv[3:0]) begin errors++; $display("FAIL frame_next_v k=%0d got %0d want %0d", k, s_nv, e.nv); end
      checks++; if (s_hb !== e.hb) begin errors++; $display("FAIL frame_hblank k=%0d got %b want %b", k, s_hb, e.hb); end
      checks++; if (s_nf !== e.nf) begin errors++; $display("FAIL frame_next_frame k=%0d got %b want %b", k, s_nf, e.nf); end
      checks++; if ({s_r, s_g, s_b} !== e.rgb) begin errors++; $display("FAIL frame_rgb k=%0d got %h want %h", k, {s_r, s_g, s_b}, e.rgb); end
      checks++; if (s_hs !== e.hs || s_vs !== e.vs) begin errors++; $display("FAIL frame_sync k=%0d got %b%b want %b%b", k, s_hs, s_vs, e.hs, e.vs); end
      checks++; if (p_hs !== ep.hs || p_vs !== ep.vs) begin errors++; $display("FAIL frame_sync_pos k=%0d got %b%b want %b%b", k, p_hs, p_vs, ep.hs, ep.vs); end
      step(12'($urandom));
    end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL frame_pulse_count got %0d want 2", pulses); end
  endtask

  // Constant white from the engine: visible pixels white, all else black.
  task automatic test_white();
    exp_t e;
    int whites = 0;
    do_reset();
    for (int i = 0; i < FL + 2; i++) begin
      e = model(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, rgb_prev, 1'b1);
      if (k >= 1 && k <= FL && {s_r, s_g, s_b} === 12'hFFF) whites++;
      checks++; if ({s_r, s_g, s_b} !== e.rgb) begin errors++; $display("FAIL white_rgb k=%0d got %h want %h", k, {s_r, s_g, s_b}, e.rgb); end
      step(12'hFFF);
    end
    checks++; if (whites !== SHA * SVA) begin errors++; $display("FAIL white_count got %0d want %0d", whites, SHA * SVA); end
  endtask

  // Reset asserted mid-frame for three clocks, then one full frame.
  task automatic test_mid_reset();
    exp_t e;
    int pulse_k = -1;
    do_reset();
    while (k < 7 * SHT + 5) step(12'($urandom));
    checks++; if (s_h !== 4'd5 || s_nv !== 4'd8) begin errors++; $display("FAIL midrst_pos got h=%0d nv=%0d want 5 8", s_h, s_nv); end
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (s_h !== 4'd0 || s_nv !== 4'd1 || s_hb !== 1'b0 || s_nf !== 1'b0) begin
        errors++; $display("FAIL midrst_cnt c=%0d got h=%0d nv=%0d hb=%b nf=%b want 0 1 0 0", c, s_h, s_nv, s_hb, s_nf); end
      checks++; if ({s_r, s_g, s_b} !== 12'h000 || s_hs !== 1'b1 || s_vs !== 1'b1) begin
        errors++; $display("FAIL midrst_out c=%0d got rgb=%h hs=%b vs=%b want 000 1 1", c, {s_r, s_g, s_b}, s_hs, s_vs); end
      if (c < 3) begin
        {in_r, in_g, in_b} = 12'($urandom);
        @(negedge clk);
      end
    end
    rst_n = 1'b1;
    k = 0;
    for (int i = 0; i < FL + 1; i++) begin
      e = model(k, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, rgb_prev, 1'b1);
      if (s_nf === 1'b1 && pulse_k < 0) pulse_k = k;
      checks++; if (s_h !== e.h[3:0] || s_nv !== e.nv[3:0]) begin errors++; $display("FAIL midrst_cnt_after k=%0d got %0d,%0d want %0d,%0d", k, s_h, s_nv, e.h, e.nv); end
      checks++; if ({s_r, s_g, s_b} !== e.rgb || s_hs !== e.hs || s_vs !== e.vs) begin
        errors++; $display("FAIL midrst_out_after k=%0d got %h %b%b want %h %b%b", k, {s_r, s_g, s_b}, s_hs, s_vs, e.rgb, e.hs, e.vs); end
      step(12'($urandom));
    end
    checks++; if (pulse_k !== FL - 1) begin errors++; $display("FAIL midrst_frame_len got %0d want %0d", pulse_k, FL - 1); end
  endtask

  // Default 640x480 timing over two lines: column count and hsync window.
  task automatic test_default_line();
    exp_t e;
    int low_cnt = 0, first_low = -1;
    do_reset();
    for (int i = 0; i < 2 * 800 + 5; i++) begin
      e = model(k, 640, 16, 96, 48, 480, 10, 2, 33, rgb_prev, 1'b1);
      if (k >= 1 && k <= 800 && d_hs === 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = k;
      end
      checks++; if (d_h !== e.h[9:0] || d_nv !== e.nv[9:0]) begin errors++; $display("FAIL def_cnt k=%0d got %0d,%0d want %0d,%0d", k, d_h, d_nv, e.h, e.nv); end
      checks++; if (d_hb !== e.hb || d_nf !== e.nf) begin errors++; $display("FAIL def_flags k=%0d got %b%b want %b%b", k, d_hb, d_nf, e.hb, e.nf); end
      checks++; if (d_hs !== e.hs || d_vs !== e.vs || {d_r, d_g, d_b} !== e.rgb) begin
        errors++; $display("FAIL def_out k=%0d got %b%b %h want %b%b %h", k, d_hs, d_vs, {d_r, d_g, d_b}, e.hs, e.vs, e.rgb); end
      step(12'($urandom));
    end
    checks++; if (low_cnt !== 96 || first_low !== 657) begin errors++; $display("FAIL def_hsync_window got len=%0d first=%0d want 96 657", low_cnt, first_low); end
  endtask

`ifdef SHADYPONG_FRAME_CNT_EN
  // 257 frames: counter follows completed frames modulo 256.
  task automatic test_frame_cnt();
    logic [7:0] want;
    do_reset();
    for (int i = 0; i < 257 * FL + 2; i++) begin
      want = 8'((k / FL) % 256);
      checks++; if (s_fc !== want) begin errors++; $display("FAIL frame_cnt k=%0d got %0d want %0d", k, s_fc, want); end
      step(12'($urandom));
    end
    checks++; if (s_fc !== 8'd1) begin errors++; $display("FAIL frame_cnt_final got %0d want 1", s_fc); end
    checks++; if (d_fc !== 8'd0) begin errors++; $display("FAIL frame_cnt_def got %0d want 0", d_fc); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_frame();
    test_white();
    test_mid_reset();
    test_default_line();
`ifdef SHADYPONG_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at k=%0d", k);
    $fatal(1, "watchdog");
  end

endmodule
